// File: rtl/ixc_unpack_288_if.sv
// Bus bundle for the 288-bit unpacker: a word-wide input handshake and a
// beat-wide output handshake.
interface ixc_unpack_288_if #(
  parameter int WIDTH = 288,
  parameter int BEAT  = 32
);
  localparam int BEATS = WIDTH / BEAT;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Both sides: a transfer happens on a rising edge where valid & ready are
  // both high; a valid source holds data stable until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BEAT-1:0]  out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/ixc_unpack_288.sv
// Wide-to-narrow serializer: one WIDTH-bit word in, BEATS beats of BEAT bits
// out, LSB beat first, with back-to-back word acceptance on the last beat.
module ixc_unpack_288 #(
  parameter int WIDTH = 288,
  parameter int BEAT  = 32
) (
  input  logic                clk,
  input  logic                rst,
  ixc_unpack_288_if.slave     bus,
  output logic                dbg_state_o
);
  localparam int BEATS = WIDTH / BEAT;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

  if ((WIDTH % BEAT) != 0) begin : g_cfg_check
    $error("ixc_unpack_288: WIDTH must be a multiple of BEAT");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [IW-1:0]    idx_q;
  logic             last_q;

  assign last_q = (state_q == SEND) && (idx_q == LAST_IDX);

  // The ready path from out_ready is combinational so a new word can be
  // taken on the same edge the last beat leaves.
  assign bus.in_ready  = !rst && ((state_q == IDLE) ||
                                  (last_q && bus.out_ready));
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = shreg_q[BEAT-1:0];
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q == SEND);
  assign dbg_state_o   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            shreg_q <= bus.in_data;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (bus.in_valid) begin
                shreg_q <= bus.in_data;
              end else begin
                shreg_q <= '0;
                state_q <= IDLE;
              end
            end else begin
              shreg_q <= shreg_q >> BEAT;
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ixc_unpack_288.sv
// Directed bench for ixc_unpack_288: beat table for a single word plus
// hand-written backpressure, back-to-back, input-stall and reset sequences.
module tb_ixc_unpack_288;
  localparam int WIDTH = 288;
  localparam int BEAT  = 32;
  localparam int BEATS = 9;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_vec_t;

  logic clk;
  logic rst;
  logic dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  ixc_unpack_288_if #(.WIDTH(WIDTH), .BEAT(BEAT)) bus ();

  ixc_unpack_288 #(.WIDTH(WIDTH), .BEAT(BEAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] mk_word(input logic [31:0] base);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < BEATS; k++) w[k*BEAT +: BEAT] = base + 32'(k);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    beat_vec_t tab[BEATS];
    int pat[4];
    int cyc;
    int exp_idx;
    logic stalled;
    logic [31:0] prev_data;
    logic [3:0]  prev_idx;

    for (int k = 0; k < BEATS; k++) begin
      tab[k].idx  = 4'(k);
      tab[k].data = 32'(k);
      tab[k].last = (k == 8);
    end
    pat = '{1, 0, 0, 1};

    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = mk_word(32'h9900_0000);
    bus.out_ready = 1'b1;

    // Reset held 3 cycles with in_valid high: nothing captured.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_idx", bus.out_idx, 0);
    chk("reset_last", bus.out_last, 0);
    chk("reset_data", bus.out_data, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    step();
    chk("no_capture_valid", bus.out_valid, 0);
    chk("no_capture_state", dbg_state, 0);

    // Single word, table-driven beat checks.
    bus.in_valid = 1'b1;
    bus.in_data  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    #1;
    chk("idle_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      #1;
      chk("single_valid", bus.out_valid, 1);
      chk("single_data", bus.out_data, tab[k].data);
      chk("single_idx", bus.out_idx, tab[k].idx);
      chk("single_last", bus.out_last, tab[k].last);
      step();
    end
    #1;
    chk("single_done_valid", bus.out_valid, 0);
    chk("single_done_busy", bus.busy, 0);
    chk("single_done_in_ready", bus.in_ready, 1);

    // Backpressure with out_ready pattern 1,0,0,1.
    for (int k = 0; k < BEATS; k++) exp_q.push_back(32'hC0DE_0000 + 32'(k));
    bus.in_valid = 1'b1;
    bus.in_data  = mk_word(32'hC0DE_0000);
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    exp_idx = 0;
    stalled = 1'b0;
    prev_data = '0;
    prev_idx = '0;
    while (exp_q.size() > 0 && cyc < 100) begin
      bus.out_ready = pat[cyc % 4][0];
      #1;
      chk("bp_valid", bus.out_valid, 1);
      if (stalled) begin
        chk("bp_hold_data", bus.out_data, prev_data);
        chk("bp_hold_idx", bus.out_idx, prev_idx);
      end
      if (bus.out_ready) begin
        chk("bp_data", bus.out_data, exp_q.pop_front());
        chk("bp_idx", bus.out_idx, 32'(exp_idx));
        exp_idx++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        prev_data = bus.out_data;
        prev_idx  = bus.out_idx;
      end
      step();
      cyc++;
    end
    chk("bp_no_timeout", (cyc < 100) ? 32'd1 : 32'd0, 1);
    chk("bp_queue_empty", exp_q.size(), 0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_done_valid", bus.out_valid, 0);
    exp_q.delete();

    // Back-to-back words A then B with no bubble.
    for (int k = 0; k < BEATS; k++) exp_q.push_back(32'hA000_0000 + 32'(k));
    for (int k = 0; k < BEATS; k++) exp_q.push_back(32'hB000_0000 + 32'(k));
    bus.in_valid = 1'b1;
    bus.in_data  = mk_word(32'hA000_0000);
    step();
    bus.in_data  = mk_word(32'hB000_0000);
    for (int i = 0; i < 2 * BEATS; i++) begin
      #1;
      chk("b2b_valid", bus.out_valid, 1);
      chk("b2b_data", bus.out_data, exp_q.pop_front());
      if (bus.in_valid) chk("b2b_in_ready", bus.in_ready, (i == 8) ? 32'd1 : 32'd0);
      step();
      if (i == 8) bus.in_valid = 1'b0;
    end
    #1;
    chk("b2b_done_valid", bus.out_valid, 0);

    // Input held valid with changing data during SEND.
    bus.in_valid = 1'b1;
    bus.in_data  = mk_word(32'hCC00_0000);
    step();
    for (int i = 0; i < BEATS; i++) begin
      bus.in_data = mk_word(32'hD000_0000 | (32'(i) << 8));
      #1;
      chk("stall_in_ready", bus.in_ready, (i == 8) ? 32'd1 : 32'd0);
      chk("stall_data", bus.out_data, 32'hCC00_0000 + 32'(i));
      step();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      #1;
      chk("stall_capt_data", bus.out_data, 32'hD000_0800 + 32'(k));
      step();
    end
    #1;
    chk("stall_done_valid", bus.out_valid, 0);

    // Reset after beat 3 accepted.
    bus.in_valid = 1'b1;
    bus.in_data  = mk_word(32'hE000_0000);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("mid_pre_data", bus.out_data, 32'hE000_0000 + 32'(k));
      step();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_out_idx", bus.out_idx, 0);
    chk("mid_in_ready", bus.in_ready, 1);
    chk("mid_busy", bus.busy, 0);
    chk("mid_data", bus.out_data, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = mk_word(32'hF000_0000);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      #1;
      chk("post_rst_data", bus.out_data, 32'hF000_0000 + 32'(k));
      chk("post_rst_idx", bus.out_idx, 32'(k));
      step();
    end
    #1;
    chk("post_rst_done", bus.out_valid, 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ixc_unpack_288.md
Name: ixc_unpack_288

Overview:
- Wide-to-narrow serializer (unpacker) for the 288-bit datapath.
- Accepts one full WIDTH-bit word over a valid/ready handshake.
- Emits the word as BEATS consecutive BEAT-bit beats, LSB beat first, over a second valid/ready handshake.
- Used as the transmit end wherever a 288-bit bus must cross a narrow link. A companion packer on the far side reassembles the words.

Parameters:
- WIDTH, 288: width of the input word; must be an exact multiple of BEAT.
- BEAT, 32: width of each output beat.
- BEATS, WIDTH/BEAT (9): number of beats per word; derived, not overridden.
- IW, clog2(BEATS) (4): width of the beat index.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word available.
- in_ready  out  1  unpacker can accept a word this cycle.
- in_data  in  WIDTH  input word; sampled only on in_valid & in_ready.
- out_valid  out  1  output beat available.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  BEAT  current beat, equal to word[(idx+1)*BEAT-1 : idx*BEAT].
- out_idx  out  IW  index of the current beat, 0..BEATS-1.
- out_last  out  1  high when out_idx == BEATS-1 and out_valid is high.
- busy  out  1  high while in SEND state.

Behaviour:
- Reset, while rst is high at a clock edge:
  - state returns to IDLE.
  - out_valid=0, out_idx=0, out_last=0, busy=0, out_data=0.
  - The shift register is cleared.
  - in_ready is forced 0 during any cycle in which rst is high.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid & in_ready, capture in_data into the shift register, set idx=0, and go to SEND.
  - First beat appears the next cycle (1-cycle latency).
- SEND:
  - out_valid=1; out_data = shreg[BEAT-1:0].
  - On out_valid & out_ready with idx < BEATS-1: shift shreg right by BEAT and increment idx.
  - On out_valid & out_ready with idx == BEATS-1 (last beat accepted):
    - If in_valid is also high, capture the new word and stay in SEND with idx=0 (back-to-back, no bubble).
    - Otherwise go to IDLE.
- in_ready = (state==IDLE & !rst) | (state==SEND & out_last & out_ready & !rst).
  - This is a combinational path from out_ready to in_ready.
  - It is intentional and permits full throughput: one word every BEATS cycles.
- Backpressure: while out_valid & !out_ready, out_data, out_idx, out_last and shreg hold exactly.
- in_valid during SEND, other than on the last-beat handshake, is ignored and in_data is not sampled. in_ready is 0 in that case, so the upstream must hold.
- Reset mid-word: the remaining beats are discarded. No partial beat is emitted after reset deasserts. out_valid is 0 in the first cycle after the reset edge.
- idx arithmetic is unsigned IW-bit. idx never exceeds BEATS-1 and does not wrap past BEATS-1 (explicit compare, not modulo 2^IW).
- WIDTH not a multiple of BEAT is a configuration error and is flagged by an elaboration-time check.
- X on in_data when not sampled must not propagate to out_data.

Test Plan:
- Single word: in_data = {9 beats 0x00000008..0x00000000, beat0 = 0x00000000, beat k = k} with out_ready=1 -> out_data 0,1,...,8 on consecutive cycles 1..9 after accept; out_last only on 8; then in_ready=1 and busy=0.
- Backpressure: out_ready toggled 1,0,0,1 pattern -> each beat held stable while stalled; 9 beats delivered in order; no duplicates or drops.
- Back-to-back: words A then B both valid, out_ready=1 -> 18 beats on 18 consecutive cycles; in_ready pulses high only on the A last-beat cycle; B beat0 follows A beat8 with no gap.
- Input stall: in_valid held high during SEND with changing in_data -> in_ready=0 and no capture until the last-beat handshake; the captured word is the value present on that cycle.
- Reset mid-word: assert rst for 1 cycle after beat 3 is accepted -> next cycle out_valid=0, out_idx=0, in_ready=1; next word sends from beat 0.
- Reset values: hold rst for 3 cycles with in_valid=1 -> in_ready=0 and out_valid=0 throughout; no capture occurs.
